// File: rtl/fetch_if.sv
// Purpose : bundles the fetch unit's control, IMEM and F/D pipeline signals.
// Latency : n/a, wiring only.
// Backpressure: n/a; master = fetch unit side, slave = core/IMEM side.
//
// Port summary (master direction):
//   in : STALL, FLUSH, PC_SEL[1:0], JAL_TGT/JALR_TGT/BR_TGT[31:0],
//        IMEM_RDATA[31:0], IMEM_VALID
//   out: IMEM_REQ, IMEM_ADDR[31:0], F_ADDR1/F_ADDR2/F_WADDR[4:0], F_OP[6:0],
//        D_PC/D_PC4/D_INSTR[31:0], D_VALID, FETCH_TIMEOUT, MISALIGN
interface fetch_if;
  logic        STALL;
  logic        FLUSH;
  logic [1:0]  PC_SEL;
  logic [31:0] JAL_TGT;
  logic [31:0] JALR_TGT;
  logic [31:0] BR_TGT;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA;
  logic        IMEM_VALID;
  logic [4:0]  F_ADDR1;
  logic [4:0]  F_ADDR2;
  logic [4:0]  F_WADDR;
  logic [6:0]  F_OP;
  logic [31:0] D_PC;
  logic [31:0] D_PC4;
  logic [31:0] D_INSTR;
  logic        D_VALID;
  logic        FETCH_TIMEOUT;
  logic        MISALIGN;

  modport master (
    input  STALL, FLUSH, PC_SEL, JAL_TGT, JALR_TGT, BR_TGT,
           IMEM_RDATA, IMEM_VALID,
    output IMEM_REQ, IMEM_ADDR, F_ADDR1, F_ADDR2, F_WADDR, F_OP,
           D_PC, D_PC4, D_INSTR, D_VALID, FETCH_TIMEOUT, MISALIGN
  );

  modport slave (
    output STALL, FLUSH, PC_SEL, JAL_TGT, JALR_TGT, BR_TGT,
           IMEM_RDATA, IMEM_VALID,
    input  IMEM_REQ, IMEM_ADDR, F_ADDR1, F_ADDR2, F_WADDR, F_OP,
           D_PC, D_PC4, D_INSTR, D_VALID, FETCH_TIMEOUT, MISALIGN
  );
endinterface

// File: rtl/fetch_unit.sv
// Purpose : instruction fetch stage -- PC, next-PC select, F/D pipeline register.
// Latency : IMEM_ADDR = PC combinationally; fetched word lands in D one edge later.
// Backpressure: STALL freezes PC/D/state/wait counter; IMEM_VALID=0 holds PC and bubbles D.
//
// Ports: CLK, RST_N (synchronous, active low) plus fetch_if.master bus
//   (redirect controls, IMEM request/response, F-field decode, D register, flags).
// Optional feature: define FETCH_MISALIGN_CHK_EN to force redirect targets to
//   word alignment and raise the sticky MISALIGN flag on misaligned targets.
module fetch_unit #(
  parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
  parameter int          WAIT_LIMIT = 16
) (
  input  logic     CLK,
  input  logic     RST_N,
  fetch_if.master  bus
);

  localparam logic [1:0]  ST_BOOT = 2'd0;
  localparam logic [1:0]  ST_RUN  = 2'd1;
  localparam logic [1:0]  ST_WAIT = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          CNT_W     = $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_LIMIT);

  logic [1:0]       state;
  logic [31:0]      pc;
  logic [31:0]      d_pc;
  logic [31:0]      d_pc4;
  logic [31:0]      d_instr;
  logic             d_valid;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_flag;
  logic             misalign_flag;

  logic             redirect;
  logic [31:0]      pc_plus4;
  logic [31:0]      tgt_raw;
  logic [31:0]      pc_tgt;
  logic             tgt_misaligned;
  logic [CNT_W-1:0] wait_cnt_nxt;

  // Natural 32-bit overflow gives the required wrap to zero.
  assign pc_plus4 = pc + 32'd4;
  assign redirect = (bus.PC_SEL != 2'b00);

  always_comb begin
    tgt_raw = bus.JAL_TGT;
    case (bus.PC_SEL)
      2'b01:   tgt_raw = bus.JAL_TGT;
      2'b10:   tgt_raw = bus.JALR_TGT;
      2'b11:   tgt_raw = bus.BR_TGT;
      default: tgt_raw = bus.JAL_TGT;
    endcase
  end

`ifdef FETCH_MISALIGN_CHK_EN
  assign tgt_misaligned = redirect && (tgt_raw[1:0] != 2'b00);
  assign pc_tgt         = {tgt_raw[31:2], 2'b00};
`else
  assign tgt_misaligned = 1'b0;
  assign pc_tgt         = tgt_raw;
`endif

  // Saturating increment; the counter never wraps back below the limit.
  assign wait_cnt_nxt = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state         <= ST_BOOT;
      pc            <= RESET_VEC;
      d_pc          <= 32'h0;
      d_pc4         <= 32'h0;
      d_instr       <= NOP_INSTR;
      d_valid       <= 1'b0;
      wait_cnt      <= '0;
      timeout_flag  <= 1'b0;
      misalign_flag <= 1'b0;
    end else if (state == ST_BOOT) begin
      // One idle cycle with no request; PC and D stay at reset values.
      state <= ST_RUN;
    end else if (!bus.STALL) begin
      if (redirect) begin
        // Redirect wins over FLUSH and over a missing IMEM response.
        pc       <= pc_tgt;
        d_instr  <= NOP_INSTR;
        d_valid  <= 1'b0;
        state    <= ST_RUN;
        wait_cnt <= '0;
        if (tgt_misaligned) misalign_flag <= 1'b1;
      end else if (bus.IMEM_VALID) begin
        pc       <= pc_plus4;
        state    <= ST_RUN;
        wait_cnt <= '0;
        if (bus.FLUSH) begin
          d_instr <= NOP_INSTR;
          d_valid <= 1'b0;
        end else begin
          d_instr <= bus.IMEM_RDATA;
          d_pc    <= pc;
          d_pc4   <= pc_plus4;
          d_valid <= 1'b1;
        end
      end else begin
        // No word this cycle (flushed or not): hold PC, bubble D, count.
        d_instr  <= NOP_INSTR;
        d_valid  <= 1'b0;
        state    <= ST_WAIT;
        wait_cnt <= wait_cnt_nxt;
        if (wait_cnt_nxt == CNT_MAX) timeout_flag <= 1'b1;
      end
    end
  end

  assign bus.IMEM_REQ      = (state != ST_BOOT);
  assign bus.IMEM_ADDR     = pc;

  assign bus.F_ADDR1       = bus.IMEM_VALID ? bus.IMEM_RDATA[19:15] : 5'd0;
  assign bus.F_ADDR2       = bus.IMEM_VALID ? bus.IMEM_RDATA[24:20] : 5'd0;
  assign bus.F_WADDR       = bus.IMEM_VALID ? bus.IMEM_RDATA[11:7]  : 5'd0;
  assign bus.F_OP          = bus.IMEM_VALID ? bus.IMEM_RDATA[6:0]   : 7'd0;

  assign bus.D_PC          = d_pc;
  assign bus.D_PC4         = d_pc4;
  assign bus.D_INSTR       = d_instr;
  assign bus.D_VALID       = d_valid;
  assign bus.FETCH_TIMEOUT = timeout_flag;
  assign bus.MISALIGN      = misalign_flag;

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose : self-checking bench for fetch_unit, directed scenarios plus random traffic.
// Latency : inputs driven at negedge, combinational outputs checked #1 later,
//           registered outputs checked #1 after the following posedge.
// Backpressure: STALL / IMEM_VALID randomised against a behavioural model.
module tb_fetch_unit;

  localparam int          WAIT_LIMIT = 16;
  localparam logic [31:0] RESET_VEC  = 32'h0000_0000;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic clk;
  logic rst_n;

  fetch_if bus ();

  fetch_unit #(
    .RESET_VEC  (RESET_VEC),
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: architectural view of the fetch stage.
  logic [31:0] m_pc;
  bit          m_booting;
  logic [31:0] m_dpc, m_dpc4, m_dinstr;
  bit          m_dvalid;
  int          m_streak;    // consecutive fetch cycles with no word delivered
  bit          m_timeout;
  bit          m_misalign;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc       = RESET_VEC;
    m_booting  = 1'b1;
    m_dpc      = 32'h0;
    m_dpc4     = 32'h0;
    m_dinstr   = NOP;
    m_dvalid   = 1'b0;
    m_streak   = 0;
    m_timeout  = 1'b0;
    m_misalign = 1'b0;
  endtask

  task automatic model_bubble();
    m_dinstr = NOP;
    m_dvalid = 1'b0;
  endtask

  task automatic drive_idle();
    bus.STALL      = 1'b0;
    bus.FLUSH      = 1'b0;
    bus.PC_SEL     = 2'b00;
    bus.JAL_TGT    = 32'h0;
    bus.JALR_TGT   = 32'h0;
    bus.BR_TGT     = 32'h0;
    bus.IMEM_RDATA = 32'h0;
    bus.IMEM_VALID = 1'b1;
  endtask

  task automatic check_regs(input string where);
    check({where, ".imem_addr"}, bus.IMEM_ADDR, m_pc);
    check({where, ".d_pc"},      bus.D_PC, m_dpc);
    check({where, ".d_pc4"},     bus.D_PC4, m_dpc4);
    check({where, ".d_instr"},   bus.D_INSTR, m_dinstr);
    check({where, ".d_valid"},   32'(bus.D_VALID), 32'(m_dvalid));
    check({where, ".timeout"},   32'(bus.FETCH_TIMEOUT), 32'(m_timeout));
    check({where, ".misalign"},  32'(bus.MISALIGN), 32'(m_misalign));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    @(posedge clk);
    #1;
    model_reset();
    check("rst.imem_addr", bus.IMEM_ADDR, RESET_VEC);
    check("rst.imem_req",  32'(bus.IMEM_REQ), 32'd0);
    check("rst.d_instr",   bus.D_INSTR, NOP);
    check("rst.d_pc",      bus.D_PC, 32'h0);
    check("rst.d_pc4",     bus.D_PC4, 32'h0);
    check("rst.d_valid",   32'(bus.D_VALID), 32'd0);
    check("rst.timeout",   32'(bus.FETCH_TIMEOUT), 32'd0);
    check("rst.misalign",  32'(bus.MISALIGN), 32'd0);
    rst_n = 1'b1;
  endtask

  // One clock: drive, check combinational outputs, step model, check registers.
  task automatic cycle(input bit stall, input bit flush, input logic [1:0] sel,
                       input logic [31:0] jal, input logic [31:0] jalr,
                       input logic [31:0] br, input logic [31:0] rdata,
                       input bit valid);
    logic [31:0] tgt;
    logic [21:0] exp_f;
    @(negedge clk);
    bus.STALL      = stall;
    bus.FLUSH      = flush;
    bus.PC_SEL     = sel;
    bus.JAL_TGT    = jal;
    bus.JALR_TGT   = jalr;
    bus.BR_TGT     = br;
    bus.IMEM_RDATA = rdata;
    bus.IMEM_VALID = valid;
    #1;
    exp_f = valid ? {5'(rdata >> 15), 5'(rdata >> 20), 5'(rdata >> 7), 7'(rdata)} : 22'd0;
    check("comb.imem_addr", bus.IMEM_ADDR, m_pc);
    check("comb.imem_req",  32'(bus.IMEM_REQ), m_booting ? 32'd0 : 32'd1);
    check("comb.f_fields",  32'({bus.F_ADDR1, bus.F_ADDR2, bus.F_WADDR, bus.F_OP}), 32'(exp_f));

    if (m_booting) begin
      m_booting = 1'b0;
    end else if (!stall) begin
      if (sel != 2'b00) begin
        tgt = (sel == 2'b01) ? jal : (sel == 2'b10) ? jalr : br;
`ifdef FETCH_MISALIGN_CHK_EN
        if (tgt % 4 != 0) m_misalign = 1'b1;
        tgt = tgt - (tgt % 4);
`endif
        m_pc     = tgt;
        m_streak = 0;
        model_bubble();
      end else if (valid) begin
        if (flush) model_bubble();
        else begin
          m_dinstr = rdata;
          m_dpc    = m_pc;
          m_dpc4   = m_pc + 32'd4;
          m_dvalid = 1'b1;
        end
        m_pc     = m_pc + 32'd4;
        m_streak = 0;
      end else begin
        model_bubble();
        if (m_streak < WAIT_LIMIT) m_streak++;
        if (m_streak == WAIT_LIMIT) m_timeout = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    check_regs("edge");
  endtask

  task automatic normal(input logic [31:0] rdata);
    cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, rdata, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved_dinstr;
    rst_n = 1'b0;
    drive_idle();

    // Reset release and straight-line fetch: 0 (boot), then 0, 4, 8.
    do_reset();
    normal(32'h0010_0093);
    check("boot.d_valid", 32'(bus.D_VALID), 32'd0);
    normal(32'h0020_0113);
    check("run1.pc",      bus.IMEM_ADDR, 32'h4);
    check("run1.d_valid", 32'(bus.D_VALID), 32'd1);
    normal(32'h0030_0193);
    check("run2.pc",      bus.IMEM_ADDR, 32'h8);
    check("run2.d_pc",    bus.D_PC, 32'h4);

    // Stall at 0x40: PC and D frozen, then resume.
    cycle(1'b0, 1'b0, 2'b01, 32'h40, 32'h0, 32'h0, 32'h0, 1'b1);
    normal(32'h00A5_0513);
    saved_dinstr = bus.D_INSTR;
    check("stall.pre_pc", bus.IMEM_ADDR, 32'h44);
    cycle(1'b0, 1'b0, 2'b01, 32'h40, 32'h0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h1234_5678, 1'b1);
      check("stall.pc", bus.IMEM_ADDR, 32'h40);
      check("stall.d_valid", 32'(bus.D_VALID), 32'd0);
    end
    normal(32'h00B5_8593);
    check("stall.resume_pc", bus.IMEM_ADDR, 32'h44);
    check("stall.resume_d",  bus.D_PC, 32'h40);
    check("stall.new_instr", bus.D_INSTR == saved_dinstr ? 32'd0 : 32'd1, 32'd1);

    // JALR redirect squashes the word even though it is valid.
    cycle(1'b0, 1'b0, 2'b10, 32'h0, 32'h200, 32'h0, 32'h0000_0033, 1'b1);
    check("jalr.pc",      bus.IMEM_ADDR, 32'h200);
    check("jalr.d_instr", bus.D_INSTR, NOP);
    check("jalr.d_valid", 32'(bus.D_VALID), 32'd0);

    // Flush without redirect: PC advances, D bubbles.
    cycle(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0000_0033, 1'b1);
    check("flush.pc",      bus.IMEM_ADDR, 32'h204);
    check("flush.d_valid", 32'(bus.D_VALID), 32'd0);

    // Branch to misaligned target.
    cycle(1'b0, 1'b0, 2'b11, 32'h0, 32'h0, 32'h102, 32'h0, 1'b1);
`ifdef FETCH_MISALIGN_CHK_EN
    check("br.pc",       bus.IMEM_ADDR, 32'h100);
    check("br.misalign", 32'(bus.MISALIGN), 32'd1);
`else
    check("br.pc",       bus.IMEM_ADDR, 32'h102);
    check("br.misalign", 32'(bus.MISALIGN), 32'd0);
`endif

    // PC wrap at the top of the address space.
    cycle(1'b0, 1'b0, 2'b01, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 1'b1);
    normal(32'h0000_0073);
    check("wrap.pc",    bus.IMEM_ADDR, 32'h0);
    check("wrap.d_pc4", bus.D_PC4, 32'h0);
    check("wrap.d_pc",  bus.D_PC, 32'hFFFF_FFFC);

    // IMEM timeout: flag rises on the 16th consecutive empty cycle and sticks.
    do_reset();
    normal(32'h0);
    normal(32'h0000_0013);
    for (int i = 1; i <= WAIT_LIMIT; i++) begin
      cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
      check("wait.pc", bus.IMEM_ADDR, 32'h4);
      check("wait.timeout", 32'(bus.FETCH_TIMEOUT), (i == WAIT_LIMIT) ? 32'd1 : 32'd0);
    end
    normal(32'h0000_0093);
    check("wait.sticky", 32'(bus.FETCH_TIMEOUT), 32'd1);
    check("wait.resume", bus.IMEM_ADDR, 32'h8);

    // Reset mid-wait clears everything.
    cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    do_reset();

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      logic [1:0]  sel;
      logic [31:0] jal, jalr, br;
      if ($urandom_range(0, 199) == 0) do_reset();
      sel  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      jal  = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      jalr = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      br   = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, sel,
            jal, jalr, br, $urandom, $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be: RESET_VEC, 32'h0000_0000, first fetch address; WAIT_LIMIT, 16, IMEM wait cycles before timeout flag.
REQ-002 Ports SHALL be, clock and reset first:
  CLK  in  1  rising-edge clock
  RST_N  in  1  synchronous active-low reset
  STALL  in  1  hazard-unit load-use stall; hold PC and D
  FLUSH  in  1  hazard-unit squash of F instruction
  PC_SEL  in  2  next-PC select: 00 PC+4, 01 JAL, 10 JALR, 11 branch
  JAL_TGT / JALR_TGT / BR_TGT  in  32 each  redirect targets
  IMEM_REQ  out  1  fetch request
  IMEM_ADDR  out  32  fetch address (= PC)
  IMEM_RDATA  in  32  instruction word
  IMEM_VALID  in  1  IMEM_RDATA valid this cycle
  F_ADDR1 / F_ADDR2 / F_WADDR  out  5 each  rs1/rs2/rd of F instruction
  F_OP  out  7  opcode of F instruction
  D_PC / D_PC4 / D_INSTR  out  32 each  F/D pipeline register
  D_VALID  out  1  D holds a real instruction
  FETCH_TIMEOUT  out  1  sticky IMEM timeout flag
  MISALIGN  out  1  sticky misaligned-target flag
REQ-003 The block SHALL use one clock (CLK) and a synchronous, active-low reset (RST_N).

Function
REQ-004 F fields SHALL be combinational slices of IMEM_RDATA ([19:15], [24:20], [11:7], [6:0]), all zero when IMEM_VALID=0.
REQ-005 IMEM_ADDR SHALL equal PC; IMEM_REQ SHALL be 1 in RUN and WAIT, 0 in BOOT.
REQ-006 State machine BOOT, RUN, WAIT: BOOT->RUN unconditionally after one cycle; RUN->WAIT when IMEM_VALID=0 and no STALL; WAIT->RUN when IMEM_VALID=1; redirect in WAIT->RUN.
REQ-007 Per-edge priority SHALL be: reset > STALL > redirect/FLUSH > IMEM wait > normal advance.
REQ-008 STALL=1: PC, D_* and state SHALL hold; wait counter SHALL hold.
REQ-009 Redirect (PC_SEL!=00, no STALL): PC <= selected target; D <= bubble, regardless of IMEM_VALID.
REQ-010 FLUSH=1, PC_SEL=00, no STALL: PC <= PC+4 if IMEM_VALID else hold; D <= bubble.
REQ-011 Bubble SHALL be D_INSTR=32'h0000_0013, D_VALID=0, D_PC/D_PC4 hold previous values.
REQ-012 Normal (IMEM_VALID=1): D_INSTR<=IMEM_RDATA, D_PC<=PC, D_PC4<=PC+4, D_VALID<=1, PC<=PC+4.
REQ-013 IMEM wait (IMEM_VALID=0, no redirect): PC holds, D <= bubble.
REQ-014 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-015 Wait counter SHALL count consecutive WAIT cycles, saturate at WAIT_LIMIT, clear on leaving WAIT; FETCH_TIMEOUT set when count reaches WAIT_LIMIT, cleared only by reset.

Reset
REQ-016 RST_N=0 at an edge: PC=RESET_VEC, state=BOOT, D_INSTR=32'h0000_0013, D_PC=0, D_PC4=0, D_VALID=0, wait counter=0, FETCH_TIMEOUT=0, MISALIGN=0.
REQ-017 Reset asserted mid-WAIT or mid-redirect SHALL discard all pending state; no fetch is issued during BOOT.

Configuration
REQ-018 Macro FETCH_MISALIGN_CHK_EN defined: on redirect with target[1:0]!=00, MISALIGN SHALL set (sticky) and PC SHALL load {target[31:2],2'b00}.
REQ-019 Macro undefined: MISALIGN SHALL be tied 0 and PC SHALL load the target unmodified.

Verification
REQ-020 Reset release, IMEM_VALID=1 always -> IMEM_ADDR 0 (BOOT, REQ=0), then 0,4,8; D_VALID=1 from second RUN cycle.
REQ-021 PC=0x40, STALL=1 for 2 cycles -> IMEM_ADDR stays 0x40, D_* unchanged; resumes 0x44 after.
REQ-022 PC_SEL=10, JALR_TGT=0x200 with STALL=0 -> next PC 0x200, D_INSTR=0x00000013, D_VALID=0.
REQ-023 IMEM_VALID=0 for WAIT_LIMIT=16 cycles -> PC holds, bubbles into D, FETCH_TIMEOUT=1 on 16th cycle and stays 1 after VALID returns.
REQ-024 With FETCH_MISALIGN_CHK_EN, BR_TGT=0x102, PC_SEL=11 -> PC=0x100, MISALIGN=1; without macro -> PC=0x102, MISALIGN=0.
REQ-025 PC=0xFFFF_FFFC, normal fetch -> next PC 0x0000_0000, D_PC4=0x0000_0000.
